// File: rtl/param_gearbox_pkg.sv
// Shared defaults for the serdes receive gearbox.
// Widths are derived inside each module from its own parameters.
package param_gearbox_pkg;

    localparam int DEF_IN_WIDTH     = 32;
    localparam int DEF_OUT_WIDTH    = 40;
    localparam bit DEF_IN_LSB_FIRST = 1'b1;

endpackage

// File: rtl/bit_reverse.sv
// Width-parametrised bit-order reversal: data_o[i] = data_i[WIDTH-1-i].
// Pure wiring, shared by the serdes receive and transmit paths.
module bit_reverse #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign data_o[i] = data_i[WIDTH-1-i];
    end

endmodule

// File: rtl/param_gearbox.sv
// Serdes receive gearbox: IN_WIDTH-bit beats in, OUT_WIDTH-bit MSB-first words out,
// with a single-bit slip for word alignment. Two register stages from beat to word.
module param_gearbox
    import param_gearbox_pkg::*;
#(
    parameter int IN_WIDTH     = DEF_IN_WIDTH,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter bit IN_LSB_FIRST = DEF_IN_LSB_FIRST
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_WIDTH-1:0]            data_in,
    input  logic                           valid_in,
    input  logic                           bitslip,
    output logic [OUT_WIDTH-1:0]           data_out,
    output logic                           valid_out,
    output logic [$clog2(OUT_WIDTH+1)-1:0] fill_level,
    output logic                           slip_done
);

    localparam int BUF_W  = OUT_WIDTH + IN_WIDTH - 1;
    localparam int FILL_W = $clog2(OUT_WIDTH + 1);
    localparam int SUM_W  = $clog2(BUF_W + 1);

    localparam logic [SUM_W-1:0] IN_W_S  = SUM_W'(IN_WIDTH);
    localparam logic [SUM_W-1:0] OUT_W_S = SUM_W'(OUT_WIDTH);

    if (IN_WIDTH < 1 || IN_WIDTH > OUT_WIDTH) begin : g_bad_widths
        $error("param_gearbox: requires 1 <= IN_WIDTH <= OUT_WIDTH");
    end

    logic [IN_WIDTH-1:0] beat_msb;

    if (IN_LSB_FIRST) begin : g_reverse
        bit_reverse #(.WIDTH(IN_WIDTH)) u_bit_reverse (
            .data_i (data_in),
            .data_o (beat_msb)
        );
    end else begin : g_forward
        assign beat_msb = data_in;
    end

    logic [IN_WIDTH-1:0]  s1_data_q;
    logic                 s1_valid_q;
    logic                 pend_q,  pend_d;
    logic [BUF_W-1:0]     buf_q,   buf_d;
    logic [FILL_W-1:0]    fill_q,  fill_d;
    logic [OUT_WIDTH-1:0] dout_q,  dout_d;
    logic                 vout_q,  vout_d;
    logic                 sdone_q, sdone_d;

    logic [IN_WIDTH-1:0]  beat;
    logic                 slip;
    logic [SUM_W-1:0]     n_bits;
    logic [SUM_W-1:0]     total;
    logic [BUF_W-1:0]     merged;

    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        slip = s1_valid_q && pend_q;
        beat = s1_data_q;
        // A slip drops the chronologically latest bit, which is the LSB once MSB-first.
        if (slip) begin
            beat[0] = 1'b0;
        end
        n_bits = slip ? (IN_W_S - SUM_W'(1)) : IN_W_S;
        total  = SUM_W'(fill_q) + n_bits;
        merged = buf_q | ((BUF_W'(beat) << (OUT_WIDTH - 1)) >> fill_q);

        pend_d  = pend_q ? !s1_valid_q : bitslip;
        buf_d   = buf_q;
        fill_d  = fill_q;
        dout_d  = dout_q;
        vout_d  = 1'b0;
        sdone_d = slip;

        if (s1_valid_q) begin
            if (total >= OUT_W_S) begin
                dout_d = merged[BUF_W-1 -: OUT_WIDTH];
                buf_d  = merged << OUT_WIDTH;
                fill_d = FILL_W'(total - OUT_W_S);
                vout_d = 1'b1;
            end else begin
                buf_d  = merged;
                fill_d = FILL_W'(total);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            pend_q     <= 1'b0;
            buf_q      <= '0;
            fill_q     <= '0;
            dout_q     <= '0;
            vout_q     <= 1'b0;
            sdone_q    <= 1'b0;
        end else begin
            s1_data_q  <= beat_msb;
            s1_valid_q <= valid_in;
            pend_q     <= pend_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            dout_q     <= dout_d;
            vout_q     <= vout_d;
            sdone_q    <= sdone_d;
        end
    end

    assign data_out   = dout_q;
    assign valid_out  = vout_q;
    assign fill_level = fill_q;
    assign slip_done  = sdone_q;

endmodule

// File: tb/tb_param_gearbox.sv
// Self-checking bench: three gearbox configurations driven in turn against a bit-stream
// scoreboard that predicts every output word and its cycle.
module tb_param_gearbox;

    typedef struct {
        int          inst;
        int          due;
        logic [39:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] din = '0;
    logic        vin   [3];
    logic        bs    [3];
    logic        vout  [3];
    logic        sdone [3];

    logic [39:0] dout0, dout2;
    logic [19:0] dout1;
    logic [5:0]  fill0, fill2;
    logic [4:0]  fill1;
    logic [39:0] dout_a [3];
    logic [5:0]  fill_a [3];

    param_gearbox #(.IN_WIDTH(32), .OUT_WIDTH(40), .IN_LSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(din[31:0]), .valid_in(vin[0]), .bitslip(bs[0]),
        .data_out(dout0), .valid_out(vout[0]), .fill_level(fill0), .slip_done(sdone[0])
    );

    param_gearbox #(.IN_WIDTH(16), .OUT_WIDTH(20), .IN_LSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(din[15:0]), .valid_in(vin[1]), .bitslip(bs[1]),
        .data_out(dout1), .valid_out(vout[1]), .fill_level(fill1), .slip_done(sdone[1])
    );

    param_gearbox #(.IN_WIDTH(40), .OUT_WIDTH(40), .IN_LSB_FIRST(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(din), .valid_in(vin[2]), .bitslip(bs[2]),
        .data_out(dout2), .valid_out(vout[2]), .fill_level(fill2), .slip_done(sdone[2])
    );

    assign dout_a[0] = dout0;
    assign dout_a[1] = {20'h0, dout1};
    assign dout_a[2] = dout2;
    assign fill_a[0] = fill0;
    assign fill_a[1] = {1'b0, fill1};
    assign fill_a[2] = fill2;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    int   act      = 0;
    bit   pend     = 1'b0;
    bit   sq [$];
    exp_t exp_q [$];

    logic [39:0] last_word  [3];
    int          slip_seen  [3];
    int          exp_slips  [3];
    int          words_seen [3];
    int          exp_words  [3];
    int          in_w  [3] = '{32, 16, 40};
    int          out_w [3] = '{40, 20, 40};
    bit          lsb_first [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side of the output: a predicted word must appear exactly on its due cycle,
    // and between words data_out must hold with valid_out low.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_q.size() > 0 && exp_q[0].inst == i && exp_q[0].due == cyc) begin
                    check($sformatf("dut%0d_valid", i), 64'(vout[i]), 64'd1);
                    check($sformatf("dut%0d_word", i), 64'(dout_a[i]), 64'(exp_q[0].data));
                    last_word[i] = exp_q[0].data;
                    void'(exp_q.pop_front());
                end else begin
                    check($sformatf("dut%0d_idle_valid", i), 64'(vout[i]), 64'd0);
                    check($sformatf("dut%0d_hold", i), 64'(dout_a[i]), 64'(last_word[i]));
                end
                if (vout[i] === 1'b1) words_seen[i]++;
                if (sdone[i] === 1'b1) slip_seen[i]++;
            end
        end
    end

    task automatic drive(input logic v, input logic [39:0] d, input logic s);
        logic [39:0] word;
        exp_t        e;
        din     = d;
        vin[act] = v;
        bs[act]  = s;
        if (s && !pend) pend = 1'b1;
        if (v) begin
            for (int i = 0; i < in_w[act]; i++) begin
                if (i == in_w[act] - 1 && pend) begin
                    pend = 1'b0;
                    exp_slips[act]++;
                end else begin
                    sq.push_back(lsb_first[act] ? d[i] : d[in_w[act]-1-i]);
                end
            end
            if (sq.size() >= out_w[act]) begin
                word = '0;
                for (int j = 0; j < out_w[act]; j++) word[out_w[act]-1-j] = sq.pop_front();
                e.inst = act;
                e.due  = cyc + 2;
                e.data = word;
                exp_q.push_back(e);
                exp_words[act]++;
            end
        end
        @(posedge clk);
        #1;
        vin[act] = 1'b0;
        bs[act]  = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic checkpoint(input string tag);
        repeat (3) idle();
        check({tag, "_fill"}, 64'(fill_a[act]), 64'(sq.size()));
        check({tag, "_slips"}, 64'(slip_seen[act]), 64'(exp_slips[act]));
        check({tag, "_words"}, 64'(words_seen[act]), 64'(exp_words[act]));
    endtask

    // Reset pulse; with junk set, a beat and a bitslip are presented during reset and must be ignored.
    task automatic do_reset(input bit junk);
        rst = 1'b1;
        if (junk) begin
            din      = {8'($urandom), 32'($urandom)};
            vin[act] = 1'b1;
            bs[act]  = 1'b1;
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        vin[act] = 1'b0;
        bs[act]  = 1'b0;
        sq.delete();
        exp_q.delete();
        pend = 1'b0;
        for (int i = 0; i < 3; i++) last_word[i] = '0;
    endtask

    function automatic logic [39:0] inc_beat(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {8'h00, b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [39:0] rnd_beat();
        return {8'($urandom), 32'($urandom)};
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0; bs[i] = 1'b0; last_word[i] = '0;
            slip_seen[i] = 0; exp_slips[i] = 0; words_seen[i] = 0; exp_words[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_dout%0d", i), 64'(dout_a[i]), 64'd0);
            check($sformatf("rst_vout%0d", i), 64'(vout[i]), 64'd0);
            check($sformatf("rst_fill%0d", i), 64'(fill_a[i]), 64'd0);
            check($sformatf("rst_sdone%0d", i), 64'(sdone[i]), 64'd0);
        end
        mon_en = 1'b1;

        // 32->40: five incrementing beats give four words and an empty buffer.
        act = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, inc_beat(i), 1'b0);
        checkpoint("inc");
        check("inc_fill_zero", 64'(fill_a[0]), 64'd0);

        // Slip requested in an idle gap is held until the next beat.
        idle();
        drive(1'b0, '0, 1'b1);
        repeat (3) idle();
        check("slip_held", 64'(slip_seen[0]), 64'd0);
        for (int i = 0; i < 5; i++) drive(1'b1, inc_beat(i), 1'b0);
        checkpoint("slip1");
        check("slip1_fill", 64'(fill_a[0]), 64'd39);
        drive(1'b1, inc_beat(5), 1'b0);
        checkpoint("slip1b");

        // Three pulses in one gap drop only one bit.
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        idle();
        drive(1'b0, '0, 1'b1);
        idle();
        drive(1'b1, rnd_beat(), 1'b0);
        drive(1'b1, rnd_beat(), 1'b0);
        checkpoint("slip3");

        // Slip arriving together with a beat applies to that beat.
        drive(1'b1, rnd_beat(), 1'b1);
        drive(1'b1, rnd_beat(), 1'b0);
        drive(1'b1, rnd_beat(), 1'b0);
        checkpoint("slip_same");

        // Reset mid-word, then a fresh stream.
        do_reset(1'b0);
        drive(1'b1, rnd_beat(), 1'b0);
        drive(1'b1, rnd_beat(), 1'b0);
        repeat (3) idle();
        do_reset(1'b1);
        check("midrst_fill", 64'(fill_a[0]), 64'd0);
        check("midrst_dout", 64'(dout_a[0]), 64'd0);
        idle();
        check("midrst_slip_ignored", 64'(slip_seen[0]), 64'(exp_slips[0]));
        for (int i = 0; i < 5; i++) drive(1'b1, rnd_beat(), 1'b0);
        checkpoint("fresh");

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, rnd_beat(), 1'b0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        checkpoint("rand32");

        // 16->20, MSB-first input, continuous stream: four words per five beats.
        act = 1;
        do_reset(1'b0);
        for (int i = 0; i < 50; i++) drive(1'b1, rnd_beat(), 1'b0);
        checkpoint("rand16");
        check("rand16_wordcount", 64'(words_seen[1]), 64'd40);
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, rnd_beat(), 1'b0);
        checkpoint("slip16");

        // 40->40: each beat is a word two cycles later, buffer stays empty.
        act = 2;
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, rnd_beat(), 1'b0);
            if (i % 2 == 1) idle();
        end
        checkpoint("same40");
        drive(1'b0, '0, 1'b1);
        drive(1'b1, rnd_beat(), 1'b0);
        drive(1'b1, rnd_beat(), 1'b0);
        checkpoint("slip40");

        repeat (3) idle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
